// File: rtl/ni_be_pkt_buf_pkg.sv
// Shared types and sizing helpers for the BE store-and-forward packet buffer.
package ni_be_pkt_buf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DROP = 2'd2
    } be_buf_state_t;

    localparam int DROP_CNT_W = 16;

    // One extra bit above the address width serves as the wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ni_be_pkt_buf_mem.sv
// Flit storage: DEPTH x (FLIT_WIDTH+1) register array holding {last,flit}.
// One synchronous write port and one asynchronous read port.
module ni_be_pkt_buf_mem #(
    parameter int FLIT_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [FLIT_WIDTH:0]      i_wdat,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [FLIT_WIDTH:0]      o_rdat
);

    logic [FLIT_WIDTH:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
    end

    assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/ni_be_pkt_buffer.sv
// Store-and-forward BE packet buffer: a packet is released the cycle after its last flit lands, over-length
// packets are dropped whole, in_ready falls only when storage is full. Drop statistics: NI_BE_PKT_BUF_STATS_EN.
module ni_be_pkt_buffer
    import ni_be_pkt_buf_pkg::*;
#(
    parameter int FLIT_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int MAX_LEN    = 8
) (
    input  logic                          i_clk_noc,
    input  logic                          i_rst_noc,
    input  logic [FLIT_WIDTH-1:0]         i_in_flit,
    input  logic                          i_in_last,
    input  logic                          i_in_valid,
    output logic                          o_in_ready,
    output logic [FLIT_WIDTH-1:0]         o_out_flit,
    output logic                          o_out_last,
    output logic                          o_out_valid,
    input  logic                          i_out_ready,
    output logic [ptr_width(DEPTH)-1:0]   o_pkt_count,
    output logic [DROP_CNT_W-1:0]         o_drop_count
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int AW    = $clog2(DEPTH);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
    localparam logic [PTR_W-1:0] DEPTH_C   = PTR_W'(DEPTH);

    if ((DEPTH < MAX_LEN) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_cfg
        $fatal(1, "ni_be_pkt_buffer: DEPTH must be a power of two and >= MAX_LEN");
    end

    be_buf_state_t    r_state, w_state_nxt;
    logic [PTR_W-1:0] r_wr_ptr, w_wr_ptr_nxt;
    logic [PTR_W-1:0] r_commit_ptr, w_commit_ptr_nxt;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_pkt_count;
    logic [LEN_W-1:0] r_flen, w_flen_nxt;
    logic [LEN_W-1:0] w_flen_inc;
    logic             w_full;
    logic             w_wr_fire;
    logic             w_rd_fire;
    logic             w_mem_we;
    logic             w_commit;
    logic             w_drop_done;
    logic [FLIT_WIDTH:0] w_rd_dat;

    assign w_full      = (r_wr_ptr - r_rd_ptr) == DEPTH_C;
    assign o_in_ready  = !i_rst_noc && ((r_state == DROP) || !w_full);
    assign w_wr_fire   = i_in_valid && o_in_ready;
    assign o_out_valid = (r_pkt_count != '0);
    assign w_rd_fire   = o_out_valid && i_out_ready;
    assign w_flen_inc  = r_flen + 1'b1;

    always_comb begin
        w_state_nxt      = r_state;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_commit_ptr_nxt = r_commit_ptr;
        w_flen_nxt       = r_flen;
        w_mem_we         = 1'b0;
        w_commit         = 1'b0;
        w_drop_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_wr_fire) begin
                    w_mem_we     = 1'b1;
                    w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                    if (i_in_last) begin
                        w_commit         = 1'b1;
                        w_commit_ptr_nxt = r_wr_ptr + 1'b1;
                    end else begin
                        w_state_nxt = FILL;
                        w_flen_nxt  = LEN_W'(1);
                    end
                end
            end
            FILL: begin
                if (w_wr_fire) begin
                    w_flen_nxt = w_flen_inc;
                    if (i_in_last) begin
                        w_mem_we         = 1'b1;
                        w_wr_ptr_nxt     = r_wr_ptr + 1'b1;
                        w_commit         = 1'b1;
                        w_commit_ptr_nxt = r_wr_ptr + 1'b1;
                        w_state_nxt      = IDLE;
                    end else if (w_flen_inc == MAX_LEN_C) begin
                        // Over-length: forget the partial packet and swallow the rest.
                        w_wr_ptr_nxt = r_commit_ptr;
                        w_state_nxt  = DROP;
                    end else begin
                        w_mem_we     = 1'b1;
                        w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                    end
                end
            end
            DROP: begin
                if (w_wr_fire && i_in_last) begin
                    w_drop_done = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk_noc or posedge i_rst_noc) begin
        if (i_rst_noc) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_pkt_count  <= '0;
            r_flen       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_commit_ptr <= w_commit_ptr_nxt;
            r_flen       <= w_flen_nxt;
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_pkt_count <= r_pkt_count + PTR_W'(w_commit) - PTR_W'(w_rd_fire && o_out_last);
        end
    end

    ni_be_pkt_buf_mem #(
        .FLIT_WIDTH (FLIT_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .i_clk   (i_clk_noc),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdat  ({i_in_last, i_in_flit}),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdat  (w_rd_dat)
    );

    assign o_out_last  = w_rd_dat[FLIT_WIDTH];
    assign o_out_flit  = w_rd_dat[FLIT_WIDTH-1:0];
    assign o_pkt_count = r_pkt_count;

`ifdef NI_BE_PKT_BUF_STATS_EN
    logic [DROP_CNT_W-1:0] r_drop_count;

    always_ff @(posedge i_clk_noc or posedge i_rst_noc) begin
        if (i_rst_noc) begin
            r_drop_count <= '0;
        end else if (w_drop_done && (r_drop_count != {DROP_CNT_W{1'b1}})) begin
            r_drop_count <= r_drop_count + 1'b1;
        end
    end

    assign o_drop_count = r_drop_count;
`else
    assign o_drop_count = '0;
`endif

endmodule

// File: tb/tb_ni_be_pkt_buffer.sv
// Directed bench for ni_be_pkt_buffer: a cycle table for simple traffic plus hand sequences for corner cases.
module tb_ni_be_pkt_buffer;

    logic        clk;
    logic        rst;
    logic [31:0] in_flit;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_flit;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  pkt_count;
    logic [15:0] drop_count;

    int n_tests;
    int n_fail;

`ifdef NI_BE_PKT_BUF_STATS_EN
    localparam logic [15:0] EXP_DROPS = 16'd1;
`else
    localparam logic [15:0] EXP_DROPS = 16'd0;
`endif

    ni_be_pkt_buffer #(.FLIT_WIDTH(32), .DEPTH(16), .MAX_LEN(8)) dut (
        .i_clk_noc    (clk),
        .i_rst_noc    (rst),
        .i_in_flit    (in_flit),
        .i_in_last    (in_last),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .o_out_flit   (out_flit),
        .o_out_last   (out_last),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_pkt_count  (pkt_count),
        .o_drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] f;
        logic        l;
        logic        ordy;
        logic        x_ir;
        logic        x_ov;
        logic [31:0] x_f;
        logic        x_l;
        int          x_pc;
    } vec_t;

    function automatic vec_t mk(logic v, logic [31:0] f, logic l, logic ordy,
                                logic x_ir, logic x_ov, logic [31:0] x_f, logic x_l, int x_pc);
        vec_t r;
        r.v = v; r.f = f; r.l = l; r.ordy = ordy;
        r.x_ir = x_ir; r.x_ov = x_ov; r.x_f = x_f; r.x_l = x_l; r.x_pc = x_pc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] f, input logic l, input logic ordy);
        in_valid  = v;
        in_flit   = f;
        in_last   = l;
        out_ready = ordy;
    endtask

    vec_t tbl[16];
    logic [31:0] exp4[17];
    int idx;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;

        // Single-flit packet, then a four-flit packet with input gaps; out_ready held high.
        tbl[0]  = mk(0, 32'h0,         0, 1, 1, 0, 32'h0,         0, 0);
        tbl[1]  = mk(1, 32'hA5A5_0001, 1, 1, 1, 0, 32'h0,         0, 0);
        tbl[2]  = mk(0, 32'h0,         0, 1, 1, 1, 32'hA5A5_0001, 1, 1);
        tbl[3]  = mk(0, 32'h0,         0, 1, 1, 0, 32'h0,         0, 0);
        tbl[4]  = mk(1, 32'h2000_0001, 0, 1, 1, 0, 32'h0,         0, 0);
        tbl[5]  = mk(0, 32'h0,         0, 1, 1, 0, 32'h0,         0, 0);
        tbl[6]  = mk(1, 32'h2000_0002, 0, 1, 1, 0, 32'h0,         0, 0);
        tbl[7]  = mk(0, 32'h0,         0, 1, 1, 0, 32'h0,         0, 0);
        tbl[8]  = mk(0, 32'h0,         0, 1, 1, 0, 32'h0,         0, 0);
        tbl[9]  = mk(1, 32'h2000_0003, 0, 1, 1, 0, 32'h0,         0, 0);
        tbl[10] = mk(1, 32'h2000_0004, 1, 1, 1, 0, 32'h0,         0, 0);
        tbl[11] = mk(0, 32'h0,         0, 1, 1, 1, 32'h2000_0001, 0, 1);
        tbl[12] = mk(0, 32'h0,         0, 1, 1, 1, 32'h2000_0002, 0, 1);
        tbl[13] = mk(0, 32'h0,         0, 1, 1, 1, 32'h2000_0003, 0, 1);
        tbl[14] = mk(0, 32'h0,         0, 1, 1, 1, 32'h2000_0004, 1, 1);
        tbl[15] = mk(0, 32'h0,         0, 1, 1, 0, 32'h0,         0, 0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].v, tbl[i].f, tbl[i].l, tbl[i].ordy);
            #1;
            chk($sformatf("t%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].x_ir));
            chk($sformatf("t%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].x_ov));
            chk($sformatf("t%0d_pkt_count", i), 32'(pkt_count), 32'(tbl[i].x_pc));
            if (tbl[i].x_ov) begin
                chk($sformatf("t%0d_out_flit", i), out_flit, tbl[i].x_f);
                chk($sformatf("t%0d_out_last", i), 32'(out_last), 32'(tbl[i].x_l));
            end
            @(negedge clk);
        end

        // Nine-flit packet is dropped whole; the following two-flit packet passes.
        for (int k = 1; k <= 9; k++) begin
            drive(1'b1, 32'h3000_0000 + 32'(k), (k == 9), 1'b1);
            #1;
            chk($sformatf("drop_in_ready_%0d", k), 32'(in_ready), 32'd1);
            chk($sformatf("drop_out_valid_%0d", k), 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        drive(1'b1, 32'h3100_0001, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b1, 32'h3100_0002, 1'b1, 1'b1);
        #1;
        chk("drop_ov_before_commit", 32'(out_valid), 32'd0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        chk("drop_p2_f1", out_flit, 32'h3100_0001);
        chk("drop_p2_v1", 32'(out_valid), 32'd1);
        chk("drop_p2_l1", 32'(out_last), 32'd0);
        @(negedge clk);
        #1;
        chk("drop_p2_f2", out_flit, 32'h3100_0002);
        chk("drop_p2_l2", 32'(out_last), 32'd1);
        chk("drop_count", 32'(drop_count), 32'(EXP_DROPS));
        @(negedge clk);
        #1;
        chk("drop_drained", 32'(out_valid), 32'd0);
        @(negedge clk);

        // Fill to DEPTH with out_ready low, then drain across the pointer wrap.
        for (int k = 0; k < 16; k++) begin
            exp4[k] = 32'h4000_0000 + 32'(k);
            drive(1'b1, exp4[k], (k == 7 || k == 15), 1'b0);
            #1;
            chk($sformatf("full_in_ready_%0d", k), 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        exp4[16] = 32'h4F00_0001;
        drive(1'b1, exp4[16], 1'b1, 1'b0);
        #1;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_pkt_count", 32'(pkt_count), 32'd2);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_stable_flit", out_flit, 32'h4000_0000);
        @(negedge clk);
        #1;
        chk("full_hold_flit", out_flit, 32'h4000_0000);
        chk("full_hold_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        idx = 0;
        for (int c = 0; c < 40 && idx < 17; c++) begin
            #1;
            if (c == 0) chk("full_rw_in_ready", 32'(in_ready), 32'd0);
            if (c == 1) chk("freed_in_ready", 32'(in_ready), 32'd1);
            if (out_valid) begin
                chk($sformatf("wrap_flit_%0d", idx), out_flit, exp4[idx]);
                chk($sformatf("wrap_last_%0d", idx), 32'(out_last),
                    32'(idx == 7 || idx == 15 || idx == 16));
                idx++;
            end
            @(negedge clk);
            if (c == 1) in_valid = 1'b0;
        end
        chk("wrap_flits_drained", 32'(idx), 32'd17);
        #1;
        chk("wrap_out_valid", 32'(out_valid), 32'd0);
        chk("wrap_pkt_count", 32'(pkt_count), 32'd0);
        @(negedge clk);

        // Commit of B coincides with A's last flit leaving.
        drive(1'b1, 32'h5A00_0001, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h5A00_0002, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h5B00_0001, 1'b0, 1'b0);
        #1;
        chk("ab_pkt_a", 32'(pkt_count), 32'd1);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        chk("ab_a1", out_flit, 32'h5A00_0001);
        @(negedge clk);
        drive(1'b1, 32'h5B00_0002, 1'b1, 1'b1);
        #1;
        chk("ab_a2", out_flit, 32'h5A00_0002);
        chk("ab_a2_last", 32'(out_last), 32'd1);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        chk("ab_pkt_same", 32'(pkt_count), 32'd1);
        chk("ab_b1_valid", 32'(out_valid), 32'd1);
        chk("ab_b1", out_flit, 32'h5B00_0001);
        @(negedge clk);
        #1;
        chk("ab_b2", out_flit, 32'h5B00_0002);
        chk("ab_b2_last", 32'(out_last), 32'd1);
        @(negedge clk);
        #1;
        chk("ab_empty", 32'(pkt_count), 32'd0);
        @(negedge clk);

        // Reset with one committed packet held and a partial packet in flight.
        drive(1'b1, 32'h6100_0001, 1'b1, 1'b0);
        @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 32'h6000_0000 + 32'(k), 1'b0, 1'b0);
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("pre_rst_pkt", 32'(pkt_count), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_pkt", 32'(pkt_count), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        drive(1'b1, 32'h6200_0001, 1'b1, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        chk("post_rst_ov", 32'(out_valid), 32'd1);
        chk("post_rst_flit", out_flit, 32'h6200_0001);
        chk("post_rst_last", 32'(out_last), 32'd1);
        @(negedge clk);
        #1;
        chk("post_rst_empty", 32'(pkt_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
